// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one sequential signed Booth multiplier among NREQ
// requesters; a watchdog turns a hung engine into an error response.
module booth_mult_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_m,
  input  logic [NREQ*W-1:0] op_q,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic              resp_err,
  output logic [2*W-1:0]    resp_product,
  output logic              busy,
  output logic              eng_start,
  output logic [W-1:0]      eng_m,
  output logic [W-1:0]      eng_q,
  input  logic              eng_done,
  input  logic [2*W-1:0]    eng_product
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [2*W-1:0]  resp_product_q, resp_product_d;
  logic            busy_q, busy_d;
  logic            eng_start_q, eng_start_d;
  logic [W-1:0]    eng_m_q, eng_m_d;
  logic [W-1:0]    eng_q_q, eng_q_d;
  logic [IW-1:0]   win_idx;

  // First asserted request at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    logic          found;
    logic [IW:0]   j;
    found   = 1'b0;
    j       = '0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
      if (!found && req[j[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = j[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    gnt_d          = '0;
    resp_valid_d   = '0;
    resp_err_d     = resp_err_q;
    resp_product_d = resp_product_q;
    eng_start_d    = 1'b0;
    eng_m_d        = eng_m_q;
    eng_q_d        = eng_q_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d       = win_idx;
          eng_m_d     = op_m[win_idx*W +: W];
          eng_q_d     = op_q[win_idx*W +: W];
          gnt_d       = NREQ'(1) << win_idx;
          eng_start_d = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A completion on the watchdog's final cycle still counts as success.
        if (eng_done) begin
          resp_product_d = eng_product;
          resp_err_d     = 1'b0;
          resp_valid_d   = NREQ'(1) << idx_q;
          state_d        = RESP;
        end else if (cnt_d == 8'(TIMEOUT)) begin
          resp_product_d = '0;
          resp_err_d     = 1'b1;
          resp_valid_d   = NREQ'(1) << idx_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + IW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      gnt_q          <= '0;
      resp_valid_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_product_q <= '0;
      busy_q         <= 1'b0;
      eng_start_q    <= 1'b0;
      eng_m_q        <= '0;
      eng_q_q        <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_product_q <= resp_product_d;
      busy_q         <= busy_d;
      eng_start_q    <= eng_start_d;
      eng_m_q        <= eng_m_d;
      eng_q_q        <= eng_q_d;
    end
  end

  assign gnt          = gnt_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_product = resp_product_q;
  assign busy         = busy_q;
  assign eng_start    = eng_start_q;
  assign eng_m        = eng_m_q;
  assign eng_q        = eng_q_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Bench for booth_mult_sched: transaction-level reference model plus a behavioural
// multiply engine, directed scenarios with literal expectations, then random traffic.
module tb_booth_mult_sched;
  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 15;
  localparam int PW      = 2*W;
  localparam int OPW     = NREQ*W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [OPW-1:0]  op_m = '0;
  logic [OPW-1:0]  op_q = '0;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] resp_valid;
  logic            resp_err;
  logic [PW-1:0]   resp_product;
  logic            busy;
  logic            eng_start;
  logic [W-1:0]    eng_m;
  logic [W-1:0]    eng_q;
  logic            eng_done = 1'b0;
  logic [PW-1:0]   eng_product = '0;

  booth_mult_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_m(op_m), .op_q(op_q),
    .gnt(gnt), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_product(resp_product), .busy(busy), .eng_start(eng_start),
    .eng_m(eng_m), .eng_q(eng_q), .eng_done(eng_done), .eng_product(eng_product)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural engine: product appears eng_lat cycles after eng_start (0 = never).
  int              eng_lat = 5;
  bit              eng_launch_pulse = 1'b0;
  bit              eng_spur = 1'b0;
  logic signed [W-1:0]  e_m = '0, e_q = '0;
  logic signed [PW-1:0] e_p;
  int              e_cnt = 0;

  always @(negedge clk) begin
    eng_done    = 1'b0;
    eng_product = PW'($urandom);
    if (eng_start) begin
      e_m   = eng_m;
      e_q   = eng_q;
      e_cnt = eng_lat;
      if (eng_launch_pulse) eng_done = 1'b1;
    end else if (e_cnt > 0) begin
      e_cnt--;
      if (e_cnt == 0) begin
        e_p         = e_m * e_q;
        eng_done    = 1'b1;
        eng_product = e_p;
      end
    end else if (eng_spur && ($urandom % 5 == 0)) begin
      eng_done = 1'b1;
    end
  end

  // Reference model in terms of edge numbers: a transaction granted on edge s may
  // complete on edges s+2 .. s+1+TIMEOUT, answers for one cycle, then frees the engine.
  int              m_edge = 0, m_s = 0, m_r = 0, m_win = 0, m_rr = 0;
  bit              m_act = 1'b0;
  logic [NREQ-1:0] m_gnt = '0, m_rv = '0;
  logic            m_start = 1'b0, m_err = 1'b0;
  logic [PW-1:0]   m_prod = '0;
  logic [W-1:0]    m_em = '0, m_eq = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_rr = 0; m_r = 0; m_edge = 0;
      m_gnt = '0; m_rv = '0; m_start = 1'b0; m_err = 1'b0;
      m_prod = '0; m_em = '0; m_eq = '0;
    end else begin
      m_edge++;
      m_gnt = '0; m_rv = '0; m_start = 1'b0;
      if (!m_act) begin
        if (req != '0) begin
          for (int k = NREQ - 1; k >= 0; k--)
            if (req[(m_rr + k) % NREQ]) m_win = (m_rr + k) % NREQ;
          m_act = 1'b1; m_s = m_edge; m_r = 0;
          m_em = op_m[m_win*W +: W];
          m_eq = op_q[m_win*W +: W];
          m_gnt = NREQ'(1) << m_win;
          m_start = 1'b1;
        end
      end else if (m_r == 0) begin
        if (m_edge >= m_s + 2) begin
          if (eng_done) begin
            m_r = m_edge; m_prod = eng_product; m_err = 1'b0;
          end else if (m_edge == m_s + 1 + TIMEOUT) begin
            m_r = m_edge; m_prod = '0; m_err = 1'b1;
          end
          if (m_r != 0) m_rv = NREQ'(1) << m_win;
        end
      end else begin
        m_act = 1'b0;
        m_rr  = (m_win + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", 64'(gnt), 64'(m_gnt));
      chk("eng_start", 64'(eng_start), 64'(m_start));
      chk("resp_valid", 64'(resp_valid), 64'(m_rv));
      chk("busy", 64'(busy), 64'(m_act));
      chk("eng_m", 64'(eng_m), 64'(m_em));
      chk("eng_q", 64'(eng_q), 64'(m_eq));
      chk("resp_err", 64'(resp_err), 64'(m_err));
      chk("resp_product", 64'(resp_product), 64'(m_prod));
      if (resp_valid != '0)
        $display("txn cycle %0d: resp_valid=%b err=%0d product=0x%h",
                 cyc, resp_valid, resp_err, resp_product);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 64'(gnt), 64'(0));
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, " resp_err"}, 64'(resp_err), 64'(0));
    chk({tag, " resp_product"}, 64'(resp_product), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " eng_start"}, 64'(eng_start), 64'(0));
    chk({tag, " eng_m"}, 64'(eng_m), 64'(0));
    chk({tag, " eng_q"}, 64'(eng_q), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(output int idx, output int at);
    idx = -1;
    at  = cyc;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
        at = cyc;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL wait_gnt: no grant within 60 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_resp(output int at);
    at = cyc;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        at = cyc;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL wait_resp: no response within 60 cycles (cycle %0d)", cyc);
  endtask

  int              g, gp, r, idx, rv_seen;
  int              exp_idx [5] = '{0, 1, 2, 3, 0};
  logic [PW-1:0]   exp_p   [5] = '{8'h31, 8'h40, 8'hF1, 8'h00, 8'h31};
  int              rr_sel;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    #1 rst_n = 1'b1;

    // Single request: 3 * -2 with a 5-cycle engine.
    @(negedge clk);
    op_m[3:0] = 4'h3; op_q[3:0] = 4'hE; req = 4'b0001;
    wait_gnt(idx, g);
    chk("t1 gnt", 64'(gnt), 64'h1);
    chk("t1 eng_start", 64'(eng_start), 64'h1);
    chk("t1 eng_m", 64'(eng_m), 64'h3);
    chk("t1 eng_q", 64'(eng_q), 64'hE);
    req = '0;
    wait_resp(r);
    chk("t1 resp_valid", 64'(resp_valid), 64'h1);
    chk("t1 product", 64'(resp_product), 64'hFA);
    chk("t1 err", 64'(resp_err), 64'h0);
    chk("t1 latency", 64'(r - g), 64'(6));

    // All four requesting: rotation 0,1,2,3,0 with back-to-back spacing L+3.
    do_reset("t2 reset");
    @(negedge clk);
    op_m = {4'h0, 4'h5, 4'h8, 4'h7};
    op_q = {4'h6, 4'hD, 4'h8, 4'h7};
    req  = 4'b1111;
    gp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(idx, g);
      chk("t2 grant idx", 64'(idx), 64'(exp_idx[k]));
      if (k > 0) chk("t2 grant spacing", 64'(g - gp), 64'(8));
      gp = g;
      if (k == 4) req = '0;
      wait_resp(r);
      chk("t2 product", 64'(resp_product), 64'(exp_p[k]));
    end

    // Pointer wrap: serve 2, then req=0101 grants 0 followed by 2.
    do_reset("t3 reset");
    @(negedge clk);
    req = 4'b0100;
    wait_gnt(idx, g);
    chk("t3 first idx", 64'(idx), 64'(2));
    req = '0;
    wait_resp(r);
    @(negedge clk);
    req = 4'b0101;
    wait_gnt(idx, g);
    chk("t3 wrap idx", 64'(idx), 64'(0));
    wait_resp(r);
    wait_gnt(idx, g);
    chk("t3 next idx", 64'(idx), 64'(2));
    req = '0;
    wait_resp(r);

    // Hung engine: error response TIMEOUT+1 cycles after the start pulse.
    eng_lat = 0;
    @(negedge clk);
    req = 4'b0010;
    wait_gnt(idx, g);
    chk("t4 idx", 64'(idx), 64'(1));
    req = '0;
    wait_resp(r);
    chk("t4 resp_valid", 64'(resp_valid), 64'h2);
    chk("t4 err", 64'(resp_err), 64'h1);
    chk("t4 product", 64'(resp_product), 64'h0);
    chk("t4 latency", 64'(r - g), 64'(TIMEOUT + 1));
    eng_lat = 5;
    op_m[15:12] = 4'h2; op_q[15:12] = 4'h3;
    @(negedge clk);
    req = 4'b1000;
    wait_gnt(idx, g);
    chk("t4 recover idx", 64'(idx), 64'(3));
    req = '0;
    wait_resp(r);
    chk("t4 recover err", 64'(resp_err), 64'h0);
    chk("t4 recover product", 64'(resp_product), 64'h06);

    // Spurious completions in IDLE and LAUNCH must be ignored.
    eng_spur = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5 idle busy", 64'(busy), 64'h0);
    eng_spur = 1'b0;
    eng_launch_pulse = 1'b1;
    op_m[3:0] = 4'h3; op_q[3:0] = 4'hE;
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(idx, g);
    chk("t5 idx", 64'(idx), 64'(0));
    req = '0;
    wait_resp(r);
    chk("t5 product", 64'(resp_product), 64'hFA);
    chk("t5 latency", 64'(r - g), 64'(6));
    eng_launch_pulse = 1'b0;

    // Completion on the watchdog's final cycle wins over the timeout.
    eng_lat = TIMEOUT;
    op_m[7:4] = 4'hF; op_q[7:4] = 4'hF;
    @(negedge clk);
    req = 4'b0010;
    wait_gnt(idx, g);
    req = '0;
    wait_resp(r);
    chk("t5 coincident err", 64'(resp_err), 64'h0);
    chk("t5 coincident product", 64'(resp_product), 64'h01);
    chk("t5 coincident latency", 64'(r - g), 64'(TIMEOUT + 1));

    // One cycle too late: timeout, and the late product is dropped.
    eng_lat = TIMEOUT + 1;
    op_m[11:8] = 4'h7; op_q[11:8] = 4'h1;
    @(negedge clk);
    req = 4'b0100;
    wait_gnt(idx, g);
    req = '0;
    wait_resp(r);
    chk("t5 late err", 64'(resp_err), 64'h1);
    chk("t5 late product", 64'(resp_product), 64'h0);
    repeat (4) @(negedge clk);

    // Reset in WAIT: everything clears, late done is ignored, rr_ptr restarts at 0.
    eng_lat = 10;
    op_m[3:0] = 4'h7; op_q[3:0] = 4'h8;
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(idx, g);
    chk("t6 idx", 64'(idx), 64'(0));
    req = '0;
    repeat (3) @(negedge clk);
    chk("t6 busy in wait", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6 mid-wait reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    rv_seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (resp_valid != '0) rv_seen++;
    end
    chk("t6 no response after reset", 64'(rv_seen), 64'(0));
    eng_lat = 5;
    op_m[7:4] = 4'h4; op_q[7:4] = 4'hC;
    req = 4'b1010;
    wait_gnt(idx, g);
    chk("t6 post-reset idx", 64'(idx), 64'(1));
    req = '0;
    wait_resp(r);
    chk("t6 post-reset product", 64'(resp_product), 64'hF0);
    chk("t6 post-reset err", 64'(resp_err), 64'h0);

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom % 3 == 0) req = NREQ'($urandom);
      op_m = OPW'($urandom);
      op_q = OPW'($urandom);
      rr_sel = int'($urandom % 20);
      eng_lat = (rr_sel == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
      eng_spur = ($urandom % 10 == 0);
      eng_launch_pulse = ($urandom % 2 == 0);
      if ($urandom % 700 == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    req = '0;
    eng_spur = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_sched.md
Name: booth_mult_sched

Overview:
- Round-robin scheduler that shares one sequential signed Booth multiply engine among NREQ requesters.
- Arbitrates between requesters, captures the winner's operands, and launches the engine with a 1-cycle start pulse.
- Waits for engine completion, then returns the signed product to the winner with a 1-cycle valid strobe.
- Includes a watchdog: a hung engine produces an error response instead of deadlocking the shared resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand width; product is 2*W bits, two's complement.
- TIMEOUT, 15, maximum cycles in WAIT before an error response (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester level request.
- op_m  in  NREQ*W  multiplicands; requester i occupies bits [i*W +: W].
- op_q  in  NREQ*W  multipliers; same packing as op_m.
- gnt  out  NREQ  one-hot 1-cycle grant; operands are captured in this cycle.
- resp_valid  out  NREQ  one-hot 1-cycle response strobe.
- resp_err  out  1  qualifies resp_valid; 1 = timeout.
- resp_product  out  2*W  signed product, valid with resp_valid.
- busy  out  1  high in every state except IDLE.
- eng_start  out  1  1-cycle start pulse to the engine.
- eng_m  out  W  registered multiplicand to the engine.
- eng_q  out  W  registered multiplier to the engine.
- eng_done  in  1  engine completion strobe.
- eng_product  in  2*W  engine result, sampled when eng_done=1.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; rr_ptr=0; all outputs 0, including gnt, resp_valid, resp_err, resp_product, eng_start, eng_m, eng_q and busy; watchdog counter=0.
- Mid-operation reset: all of the above apply immediately. The in-flight transaction is dropped with no response. Any later eng_done is ignored until the next LAUNCH.
- States: IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - If req is nonzero at a clk edge, select the winner: the first asserted bit searching upward from rr_ptr, wrapping NREQ-1 -> 0.
  - Latch winner index, eng_m and eng_q from that requester's op_m/op_q slices.
  - Go to LAUNCH.
  - If req is zero, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - gnt[idx]=1 and eng_start=1. Go to WAIT; watchdog counter cleared to 0.
  - Requester must drop req in the cycle after gnt; if req is still high when IDLE is re-entered, it is a new request.
- WAIT:
  - eng_m and eng_q are held stable.
  - eng_done=1: capture eng_product into resp_product, resp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT without eng_done: resp_product=0, resp_err=1, go to RESP.
  - eng_done and timeout in the same cycle: eng_done wins.
- RESP (exactly 1 cycle):
  - resp_valid[idx]=1.
  - rr_ptr = idx+1 modulo NREQ (idx=NREQ-1 wraps to 0).
  - Go to IDLE.
  - resp_product and resp_err hold their values until the next RESP.
- eng_done outside WAIT (including in the LAUNCH cycle) is ignored.
- Latency:
  - req sampled -> gnt/eng_start: 1 cycle.
  - eng_done -> resp_valid: 1 cycle.
  - Minimum turnaround between back-to-back grants: engine latency + 3 cycles.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Width: the product is passed through unmodified at 2*W bits; the scheduler performs no arithmetic on it.
- Invariant: gnt and resp_valid are each zero or one-hot. busy = (state != IDLE).

Test Plan:
- Single request, engine model returns in 5 cycles: req[0]=1, m=4'd3, q=4'hE (-2) -> gnt[0] 1 cycle later; eng_m=3, eng_q=E; resp_valid[0] with resp_product=8'hFA (-6), resp_err=0.
- All four req held high with distinct operands, e.g. (7,7),(-8,-8),(5,-3),(0,6) -> grant order 0,1,2,3,0; products 8'h31, 8'h40, 8'hF1, 8'h00.
- Wrap: rr_ptr=3 after serving requester 2, with req=4'b0101 -> requester 0 granted; next IDLE with the same req grants requester 2.
- Timeout: engine never asserts eng_done -> resp_valid[idx] exactly TIMEOUT+1 cycles after eng_start, with resp_err=1 and resp_product=0; next request completes normally.
- Spurious and coincident done: eng_done pulsed in IDLE and in LAUNCH -> ignored. eng_done on the same cycle the counter reaches TIMEOUT -> resp_err=0 with the engine product.
- Reset mid-WAIT: rst_n=0 for 1 cycle while in WAIT -> all outputs 0 immediately, rr_ptr=0. Late eng_done -> no resp_valid. req[1] afterward -> granted normally.
